// File: rtl/song_sequencer_param.sv
// Multi-song note sequencer. It reads a length header and then {dur, note} entries from a
// synchronous ROM, and drives one note word at a time with a silent gap after each note.
module song_sequencer_param #(
  parameter int unsigned SONG_W       = 2,
  parameter int unsigned IDX_W        = 7,
  parameter int unsigned NOTE_W       = 10,
  parameter int unsigned DUR_W        = 4,
  parameter int unsigned TICK_CYCLES  = 12500000,
  parameter int unsigned PAUSE_CYCLES = 10000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SONG_W-1:0]         song_sel,
  input  logic                      loop_en,
  input  logic                      hold,
  output logic [SONG_W+IDX_W-1:0]   rom_addr,
  input  logic [DUR_W+NOTE_W-1:0]   rom_data,
  output logic [NOTE_W-1:0]         note_and_pitch,
  output logic                      note_valid,
  output logic [IDX_W-1:0]          note_index,
  output logic                      song_done
);

  localparam logic [31:0] TickLast  = TICK_CYCLES - 1;
  localparam logic [31:0] PauseLast = (PAUSE_CYCLES == 0) ? 32'd0 : PAUSE_CYCLES - 1;

  typedef enum logic [2:0] {
    StIdle, StLenRd, StLenCap, StNoteRd, StNoteCap, StPlay, StGap, StDone
  } state_e;

  state_e              state_q;
  logic [SONG_W-1:0]   sel_q;
  logic [IDX_W-1:0]    len_q;
  logic [NOTE_W-1:0]   note_q;
  logic [DUR_W-1:0]    dur_q;
  logic [31:0]         tick_cnt;
  logic [31:0]         gap_cnt;
  logic [DUR_W-1:0]    unit_cnt;

  logic [IDX_W-1:0]    rom_len;
  logic [NOTE_W-1:0]   rom_note;
  logic [DUR_W-1:0]    rom_dur;
  logic [IDX_W-1:0]    exit_index;
  state_e              exit_state;

  assign rom_len  = rom_data[IDX_W-1:0];
  assign rom_note = rom_data[NOTE_W-1:0];
  assign rom_dur  = rom_data[NOTE_W +: DUR_W];

  // Where to go once a note and its gap are over; loop_en only matters here.
  always_comb begin
    exit_index = note_index;
    exit_state = StDone;
    if (note_index < len_q) begin
      exit_index = note_index + 1'b1;
      exit_state = StNoteRd;
    end else if (loop_en) begin
      exit_index = IDX_W'(1);
      exit_state = StNoteRd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      sel_q          <= '0;
      len_q          <= '0;
      note_q         <= '0;
      dur_q          <= '0;
      tick_cnt       <= '0;
      gap_cnt        <= '0;
      unit_cnt       <= '0;
      rom_addr       <= '0;
      note_and_pitch <= '0;
      note_valid     <= 1'b0;
      note_index     <= '0;
      song_done      <= 1'b0;
    end else begin
      sel_q <= song_sel;
      if (song_sel != sel_q) begin
        state_q        <= StIdle;
        tick_cnt       <= '0;
        gap_cnt        <= '0;
        unit_cnt       <= '0;
        rom_addr       <= '0;
        note_and_pitch <= '0;
        note_valid     <= 1'b0;
        note_index     <= '0;
        song_done      <= 1'b0;
      end else if (hold) begin
        // Position is frozen; the ROM keeps presenting the same word.
        note_and_pitch <= '0;
        note_valid     <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (sel_q != '0) begin
              rom_addr <= {sel_q, IDX_W'(0)};
              state_q  <= StLenRd;
            end
          end
          StLenRd:  state_q <= StLenCap;
          StLenCap: begin
            len_q <= rom_len;
            if (rom_len == '0) begin
              song_done <= 1'b1;
              state_q   <= StDone;
            end else begin
              note_index <= IDX_W'(1);
              rom_addr   <= {sel_q, IDX_W'(1)};
              state_q    <= StNoteRd;
            end
          end
          StNoteRd: state_q <= StNoteCap;
          StNoteCap: begin
            note_q         <= rom_note;
            dur_q          <= (rom_dur == '0) ? DUR_W'(1) : rom_dur;
            note_and_pitch <= rom_note;
            note_valid     <= 1'b1;
            tick_cnt       <= '0;
            unit_cnt       <= '0;
            state_q        <= StPlay;
          end
          StPlay: begin
            if (tick_cnt == TickLast && unit_cnt == dur_q - 1'b1) begin
              tick_cnt       <= '0;
              unit_cnt       <= '0;
              note_and_pitch <= '0;
              note_valid     <= 1'b0;
              if (PAUSE_CYCLES > 0) begin
                gap_cnt <= '0;
                state_q <= StGap;
              end else begin
                note_index <= exit_index;
                rom_addr   <= {sel_q, exit_index};
                song_done  <= (exit_state == StDone);
                state_q    <= exit_state;
              end
            end else begin
              // Re-asserted every cycle so playback resumes right after a hold.
              note_and_pitch <= note_q;
              note_valid     <= 1'b1;
              if (tick_cnt == TickLast) begin
                tick_cnt <= '0;
                unit_cnt <= unit_cnt + 1'b1;
              end else begin
                tick_cnt <= tick_cnt + 32'd1;
              end
            end
          end
          StGap: begin
            if (gap_cnt == PauseLast) begin
              note_index <= exit_index;
              rom_addr   <= {sel_q, exit_index};
              song_done  <= (exit_state == StDone);
              state_q    <= exit_state;
            end else begin
              gap_cnt <= gap_cnt + 32'd1;
            end
          end
          StDone: begin
            note_and_pitch <= '0;
            note_valid     <= 1'b0;
            song_done      <= 1'b1;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule
